// File: rtl/id_ex_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_reg_if
// Brief    : ID->EX pipeline bus: ID-side operands, writeback port, EX outputs.
// Revision : 1.0
// ============================================================================
interface id_ex_reg_if #(
  parameter int CNT_W = 16
);
  logic             stall_i;
  logic             flush_i;
  logic             id_valid_i;
  logic [31:0]      id_pc_i;
  logic [31:0]      id_instr_i;
  logic [31:0]      id_imm_i;
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic [4:0]       id_rd_addr_i;
  logic [31:0]      id_rs1_data_i;
  logic [31:0]      id_rs2_data_i;
  logic             id_rd_wren_i;
  logic             id_mem_rden_i;
  logic             wb_rd_wren_i;
  logic [4:0]       wb_rd_addr_i;
  logic [31:0]      wb_rd_data_i;

  logic             ex_valid_o;
  logic             ex_rd_wren_o;
  logic             ex_mem_rden_o;
  logic [31:0]      ex_pc_o;
  logic [31:0]      ex_instr_o;
  logic [31:0]      ex_imm_o;
  logic [31:0]      ex_rs1_data_o;
  logic [31:0]      ex_rs2_data_o;
  logic [4:0]       ex_rs1_addr_o;
  logic [4:0]       ex_rs2_addr_o;
  logic [4:0]       ex_rd_addr_o;
  logic             load_use_stall_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  modport master (
    output stall_i, flush_i, id_valid_i, id_pc_i, id_instr_i, id_imm_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_rs1_data_i,
           id_rs2_data_i, id_rd_wren_i, id_mem_rden_i,
           wb_rd_wren_i, wb_rd_addr_i, wb_rd_data_i,
    input  ex_valid_o, ex_rd_wren_o, ex_mem_rden_o, ex_pc_o, ex_instr_o,
           ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_rs1_addr_o,
           ex_rs2_addr_o, ex_rd_addr_o, load_use_stall_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, id_valid_i, id_pc_i, id_instr_i, id_imm_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_rs1_data_i,
           id_rs2_data_i, id_rd_wren_i, id_mem_rden_i,
           wb_rd_wren_i, wb_rd_addr_i, wb_rd_data_i,
    output ex_valid_o, ex_rd_wren_o, ex_mem_rden_o, ex_pc_o, ex_instr_o,
           ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_rs1_addr_o,
           ex_rs2_addr_o, ex_rd_addr_o, load_use_stall_o, bubble_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_reg
// Brief    : ID/EX pipeline register with load-use bubble, flush, stall,
//            writeback bypass and saturating bubble counter.
// Revision : 1.0
// ============================================================================
module id_ex_reg #(
  parameter int CNT_W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  id_ex_reg_if.slave   bus
);
  localparam logic [4:0] c_X0 = 5'd0;

  logic             r_valid, r_rd_wren, r_mem_rden;
  logic [31:0]      r_pc, r_instr, r_imm, r_rs1_data, r_rs2_data;
  logic [4:0]       r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic        w_load_use;
  logic        w_wb_act;
  logic        w_hit_id1, w_hit_id2, w_hit_ex1, w_hit_ex2;
  logic [31:0] w_rs1_cap, w_rs2_cap;
  logic        w_bubble;

  assign w_load_use = r_valid & r_mem_rden & (r_rd_addr != c_X0) & bus.id_valid_i &
                      ((bus.id_rs1_addr_i == r_rd_addr) | (bus.id_rs2_addr_i == r_rd_addr)) &
                      ~bus.flush_i;

  // x0 is excluded here, so a zero-register operand always comes from the file.
  assign w_wb_act  = bus.wb_rd_wren_i & (bus.wb_rd_addr_i != c_X0);
  assign w_hit_id1 = w_wb_act & (bus.wb_rd_addr_i == bus.id_rs1_addr_i);
  assign w_hit_id2 = w_wb_act & (bus.wb_rd_addr_i == bus.id_rs2_addr_i);
  assign w_hit_ex1 = w_wb_act & r_valid & (bus.wb_rd_addr_i == r_rs1_addr);
  assign w_hit_ex2 = w_wb_act & r_valid & (bus.wb_rd_addr_i == r_rs2_addr);

  assign w_rs1_cap = w_hit_id1 ? bus.wb_rd_data_i : bus.id_rs1_data_i;
  assign w_rs2_cap = w_hit_id2 ? bus.wb_rd_data_i : bus.id_rs2_data_i;
  assign w_bubble  = ~bus.flush_i & ~bus.stall_i & w_load_use;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid    <= 1'b0;
      r_rd_wren  <= 1'b0;
      r_mem_rden <= 1'b0;
    end else if (bus.flush_i || w_bubble) begin
      r_valid    <= 1'b0;
      r_rd_wren  <= 1'b0;
      r_mem_rden <= 1'b0;
    end else if (!bus.stall_i) begin
      r_valid    <= bus.id_valid_i;
      r_rd_wren  <= bus.id_rd_wren_i & bus.id_valid_i;
      r_mem_rden <= bus.id_mem_rden_i & bus.id_valid_i;
    end
  end

  // Datapath fields: cleared on flush, refreshed from writeback while held,
  // left untouched by a bubble since the controls already mark it dead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
    end else if (bus.flush_i) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
    end else if (bus.stall_i) begin
      if (w_hit_ex1) r_rs1_data <= bus.wb_rd_data_i;
      if (w_hit_ex2) r_rs2_data <= bus.wb_rd_data_i;
    end else if (!w_load_use) begin
      r_pc       <= bus.id_pc_i;
      r_instr    <= bus.id_instr_i;
      r_imm      <= bus.id_imm_i;
      r_rs1_addr <= bus.id_rs1_addr_i;
      r_rs2_addr <= bus.id_rs2_addr_i;
      r_rd_addr  <= bus.id_rd_addr_i;
      r_rs1_data <= w_rs1_cap;
      r_rs2_data <= w_rs2_cap;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && !(&r_bubble_cnt)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.ex_valid_o       = r_valid;
  assign bus.ex_rd_wren_o     = r_rd_wren;
  assign bus.ex_mem_rden_o    = r_mem_rden;
  assign bus.ex_pc_o          = r_pc;
  assign bus.ex_instr_o       = r_instr;
  assign bus.ex_imm_o         = r_imm;
  assign bus.ex_rs1_data_o    = r_rs1_data;
  assign bus.ex_rs2_data_o    = r_rs2_data;
  assign bus.ex_rs1_addr_o    = r_rs1_addr;
  assign bus.ex_rs2_addr_o    = r_rs2_addr;
  assign bus.ex_rd_addr_o     = r_rd_addr;
  assign bus.load_use_stall_o = w_load_use;
  assign bus.bubble_cnt_o     = r_bubble_cnt;
endmodule
`default_nettype wire
